// File: rtl/fir_cmplx_seq_if.sv
// Control bundle between the complex FIR tap sequencer and its datapath.
// Carries FIFO flags/strobes, history RAM and coefficient addresses, and MAC controls.
//
// Signals:
//   in_empty, in_rd_en            input FIFO flag / pop
//   hist_wr_en, hist_zero         history write strobe / write-zero select
//   hist_wr_addr, hist_rd_addr    history RAM addresses
//   coef_addr                     coefficient ROM address
//   mac_en, mac_clear, mac_last   MAC strobes
//   out_full, out_wr_en           output FIFO flag / push
//   busy                          sequencer not idle in S_READ
// Modports:
//   master  the sequencer side (drives strobes and addresses)
//   slave   the datapath side (drives the FIFO flags)
interface fir_cmplx_seq_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int COEF_WIDTH = 5
);
    logic                  in_empty;
    logic                  in_rd_en;
    logic                  hist_wr_en;
    logic                  hist_zero;
    logic [ADDR_WIDTH-1:0] hist_wr_addr;
    logic [ADDR_WIDTH-1:0] hist_rd_addr;
    logic [COEF_WIDTH-1:0] coef_addr;
    logic                  mac_en;
    logic                  mac_clear;
    logic                  mac_last;
    logic                  out_full;
    logic                  out_wr_en;
    logic                  busy;

    modport master (
        input  in_empty, out_full,
        output in_rd_en, hist_wr_en, hist_zero, hist_wr_addr,
        output hist_rd_addr, coef_addr, mac_en, mac_clear,
        output mac_last, out_wr_en, busy
    );

    modport slave (
        output in_empty, out_full,
        input  in_rd_en, hist_wr_en, hist_zero, hist_wr_addr,
        input  hist_rd_addr, coef_addr, mac_en, mac_clear,
        input  mac_last, out_wr_en, busy
    );
endinterface

// File: rtl/fir_cmplx_seq.sv
// Time-multiplexed tap sequencer for the complex channel FIR.
// Fills a circular history RAM from the input FIFO and sweeps one complex MAC over all taps.
//
// Ports:
//   clock  system clock
//   reset  asynchronous active-low reset
//   bus    fir_cmplx_seq_if.master (FIFO flags in; strobes and addresses out)
module fir_cmplx_seq #(
    parameter int NUM_TAPS    = 20,
    parameter int ADDR_WIDTH  = 5,
    parameter int DECIM       = 1,
    parameter int MAC_LATENCY = 2
) (
    input  logic            clock,
    input  logic            reset,
    fir_cmplx_seq_if.master bus
);
    localparam int AW = ADDR_WIDTH;
    localparam int CW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int LW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_READ,
        S_MAC,
        S_DRAIN,
        S_WRITE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_clr_cnt;
    logic [AW-1:0]   r_newest;
    logic [DW-1:0]   r_decim_cnt;
    logic [CW-1:0]   r_tap;
    logic [LW-1:0]   r_drain;

    logic            w_pop;
    logic            w_last_tap;
    logic            w_decim_done;
    logic            w_drain_done;

    assign w_pop        = (r_state == S_READ) && !bus.in_empty;
    assign w_last_tap   = (r_tap == CW'(NUM_TAPS - 1));
    assign w_decim_done = (r_decim_cnt == DW'(DECIM - 1));
    assign w_drain_done = (r_drain == LW'(MAC_LATENCY - 1));

    always_comb begin
        w_next           = r_state;
        bus.in_rd_en     = 1'b0;
        bus.hist_wr_en   = 1'b0;
        bus.hist_zero    = 1'b0;
        bus.hist_wr_addr = '0;
        bus.hist_rd_addr = '0;
        bus.coef_addr    = '0;
        bus.mac_en       = 1'b0;
        bus.mac_clear    = 1'b0;
        bus.mac_last     = 1'b0;
        bus.out_wr_en    = 1'b0;
        bus.busy         = 1'b1;
        unique case (r_state)
            S_CLEAR: begin
                bus.hist_wr_en   = 1'b1;
                bus.hist_zero    = 1'b1;
                bus.hist_wr_addr = r_clr_cnt;
                if (&r_clr_cnt)
                    w_next = S_READ;
            end
            S_READ: begin
                bus.busy         = 1'b0;
                bus.in_rd_en     = w_pop;
                bus.hist_wr_en   = w_pop;
                bus.hist_wr_addr = r_wr_ptr;
                if (w_pop && w_decim_done)
                    w_next = S_MAC;
            end
            S_MAC: begin
                bus.mac_en       = 1'b1;
                bus.coef_addr    = r_tap;
                // Newest sample pairs with tap 0; older samples wrap backwards.
                bus.hist_rd_addr = r_newest - AW'(r_tap);
                bus.mac_clear    = (r_tap == '0);
                bus.mac_last     = w_last_tap;
                if (w_last_tap)
                    w_next = (MAC_LATENCY == 0) ? S_WRITE : S_DRAIN;
            end
            S_DRAIN: begin
                if (w_drain_done)
                    w_next = S_WRITE;
            end
            S_WRITE: begin
                bus.out_wr_en = !bus.out_full;
                if (!bus.out_full)
                    w_next = S_READ;
            end
            default: w_next = S_CLEAR;
        endcase
        // Strobes must drop while reset is held, without waiting for a clock.
        if (!reset) begin
            w_next           = S_CLEAR;
            bus.in_rd_en     = 1'b0;
            bus.hist_wr_en   = 1'b0;
            bus.hist_zero    = 1'b0;
            bus.hist_wr_addr = '0;
            bus.hist_rd_addr = '0;
            bus.coef_addr    = '0;
            bus.mac_en       = 1'b0;
            bus.mac_clear    = 1'b0;
            bus.mac_last     = 1'b0;
            bus.out_wr_en    = 1'b0;
            bus.busy         = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_CLEAR;
            r_wr_ptr    <= '0;
            r_clr_cnt   <= '0;
            r_newest    <= '0;
            r_decim_cnt <= '0;
            r_tap       <= '0;
            r_drain     <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_CLEAR: r_clr_cnt <= r_clr_cnt + 1'b1;
                S_READ: begin
                    if (w_pop) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (w_decim_done) begin
                            r_decim_cnt <= '0;
                            r_newest    <= r_wr_ptr;
                            r_tap       <= '0;
                        end else begin
                            r_decim_cnt <= r_decim_cnt + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    r_tap   <= w_last_tap ? '0 : r_tap + 1'b1;
                    r_drain <= '0;
                end
                S_DRAIN: r_drain <= r_drain + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_cmplx_seq.sv
// Directed testbench for fir_cmplx_seq (default build plus a DECIM=8 build).
// Each scenario task drives vectors and checks hand-derived expectations inline.
module tb_fir_cmplx_seq;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [4:0] ptr = '0;

    always #5 clock = ~clock;

    fir_cmplx_seq_if #(.ADDR_WIDTH(5), .COEF_WIDTH(5)) bus ();
    fir_cmplx_seq_if #(.ADDR_WIDTH(5), .COEF_WIDTH(5)) bus8 ();

    fir_cmplx_seq #(
        .NUM_TAPS(20), .ADDR_WIDTH(5), .DECIM(1), .MAC_LATENCY(2)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    fir_cmplx_seq #(
        .NUM_TAPS(20), .ADDR_WIDTH(5), .DECIM(8), .MAC_LATENCY(2)
    ) dut8 (
        .clock(clock), .reset(reset), .bus(bus8)
    );

    task automatic test_reset();
        logic [4:0] v;
        bus.in_empty = 1'b1; bus.out_full = 1'b0;
        bus8.in_empty = 1'b1; bus8.out_full = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        v = {bus.hist_wr_en, bus.in_rd_en, bus.mac_en, bus.out_wr_en, bus.busy};
        n_chk++;
        if (v !== 5'b00001) $display("FAIL reset_strobes got=%b exp=00001", v);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            n_chk++;
            if ({bus.hist_wr_en, bus.hist_zero} !== 2'b11 || bus.hist_wr_addr !== 5'(i))
                $display("FAIL clear_%0d got en/zero=%b%b addr=%0d exp 11 addr=%0d",
                         i, bus.hist_wr_en, bus.hist_zero, bus.hist_wr_addr, i);
            else n_pass++;
            @(negedge clock);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if ({bus.busy, bus.in_rd_en, bus.hist_wr_en} !== 3'b000)
                $display("FAIL idle_%0d got busy/rd/wr=%b%b%b exp=000",
                         i, bus.busy, bus.in_rd_en, bus.hist_wr_en);
            else n_pass++;
            @(negedge clock);
            #1;
        end
        n_chk++;
        if (bus8.busy !== 1'b0) $display("FAIL idle_d8 got busy=%b exp=0", bus8.busy);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [4:0]  newest;
        logic [13:0] got, exp;
        @(negedge clock);
        bus.in_empty = 1'b0;
        #1;
        n_chk++;
        if ({bus.in_rd_en, bus.hist_wr_en, bus.hist_zero} !== 3'b110 || bus.hist_wr_addr !== ptr)
            $display("FAIL single_pop got rd/wr/z=%b%b%b addr=%0d exp 110 addr=%0d",
                     bus.in_rd_en, bus.hist_wr_en, bus.hist_zero, bus.hist_wr_addr, ptr);
        else n_pass++;
        newest = ptr;
        ptr = ptr + 5'd1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            bus.in_empty = 1'b1;
            #1;
            got = {bus.mac_en, bus.mac_clear, bus.mac_last, bus.coef_addr,
                   bus.hist_rd_addr, bus.in_rd_en};
            exp = {1'b1, k == 0, k == 19, 5'(k), 5'(newest - 5'(k)), 1'b0};
            n_chk++;
            if (got !== exp) $display("FAIL single_tap_%0d got=%h exp=%h", k, got, exp);
            else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #1;
            n_chk++;
            if ({bus.mac_en, bus.out_wr_en, bus.in_rd_en, bus.busy} !== 4'b0001)
                $display("FAIL single_drain_%0d got=%b%b%b%b exp=0001", i,
                         bus.mac_en, bus.out_wr_en, bus.in_rd_en, bus.busy);
            else n_pass++;
        end
        @(negedge clock);
        #1;
        n_chk++;
        if (bus.out_wr_en !== 1'b1) $display("FAIL single_push got=%b exp=1", bus.out_wr_en);
        else n_pass++;
        @(negedge clock);
        #1;
        n_chk++;
        if ({bus.out_wr_en, bus.busy} !== 2'b00)
            $display("FAIL single_after got wr/busy=%b%b exp=00", bus.out_wr_en, bus.busy);
        else n_pass++;
    endtask

    task automatic test_stream();
        int pops = 0, pushes = 0, last_push = -1, k = 0, total = 1, bad = 0;
        logic [4:0] newest = '0;
        for (int c = 0; c < 3000 && pushes < 100; c++) begin
            @(negedge clock);
            bus.in_empty = (pops >= 100);
            #1;
            if (bus.mac_en) begin
                if (bus.hist_rd_addr !== 5'(newest - 5'(k)) || bus.in_rd_en !== 1'b0) begin
                    bad++;
                    $display("FAIL stream_tap got rd=%0d pop=%b exp rd=%0d pop=0",
                             bus.hist_rd_addr, bus.in_rd_en, 5'(newest - 5'(k)));
                end
                k++;
            end
            if (bus.in_rd_en) begin
                n_chk++;
                if (bus.hist_wr_addr !== ptr)
                    $display("FAIL stream_wr got=%0d exp=%0d", bus.hist_wr_addr, ptr);
                else n_pass++;
                total++;
                if (total == 33) begin
                    n_chk++;
                    if (bus.hist_wr_addr !== 5'd0)
                        $display("FAIL stream_wrap got=%0d exp=0", bus.hist_wr_addr);
                    else n_pass++;
                end
                newest = ptr;
                ptr = ptr + 5'd1;
                pops++;
                k = 0;
            end
            if (bus.out_wr_en) begin
                if (last_push >= 0) begin
                    n_chk++;
                    if (c - last_push !== 24)
                        $display("FAIL stream_gap got=%0d exp=24", c - last_push);
                    else n_pass++;
                end
                last_push = c;
                pushes++;
            end
        end
        n_chk++;
        if (bad !== 0) $display("FAIL stream_taps got=%0d bad exp=0", bad);
        else n_pass++;
        n_chk++;
        if (pushes !== 100 || pops !== 100)
            $display("FAIL stream_count got pops=%0d pushes=%0d exp 100/100", pops, pushes);
        else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        bit seen = 0;
        @(negedge clock);
        bus.in_empty = 1'b0;
        bus.out_full = 1'b1;
        #1;
        n_chk++;
        if (bus.in_rd_en !== 1'b1 || bus.hist_wr_addr !== ptr)
            $display("FAIL bp_pop got rd=%b addr=%0d exp 1 addr=%0d",
                     bus.in_rd_en, bus.hist_wr_addr, ptr);
        else n_pass++;
        ptr = ptr + 5'd1;
        repeat (22) @(negedge clock);
        #1;
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if ({bus.out_wr_en, bus.in_rd_en, bus.mac_en, bus.busy} !== 4'b0001)
                $display("FAIL bp_hold_%0d got=%b%b%b%b exp=0001", i,
                         bus.out_wr_en, bus.in_rd_en, bus.mac_en, bus.busy);
            else n_pass++;
            @(negedge clock);
            #1;
        end
        bus.out_full = 1'b0;
        #1;
        n_chk++;
        if ({bus.out_wr_en, bus.in_rd_en} !== 2'b10)
            $display("FAIL bp_push got wr/rd=%b%b exp=10", bus.out_wr_en, bus.in_rd_en);
        else n_pass++;
        @(negedge clock);
        #1;
        n_chk++;
        if (bus.in_rd_en !== 1'b1 || bus.hist_wr_addr !== ptr)
            $display("FAIL bp_next_pop got rd=%b addr=%0d exp 1 addr=%0d",
                     bus.in_rd_en, bus.hist_wr_addr, ptr);
        else n_pass++;
        ptr = ptr + 5'd1;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clock);
            bus.in_empty = 1'b1;
            #1;
            seen = bus.out_wr_en;
        end
        n_chk++;
        if (!seen) $display("FAIL bp_final_push got=none exp=push within 40 cycles");
        else n_pass++;
    endtask

    task automatic test_decim8();
        int pops = 0, pushes = 0, idle = 0;
        for (int c = 0; c < 2000 && idle < 60; c++) begin
            @(negedge clock);
            bus8.in_empty = (pops >= 100);
            #1;
            if (bus8.in_rd_en) pops++;
            if (pops >= 100) idle++;
            if (bus8.out_wr_en) begin
                pushes++;
                n_chk++;
                if (pops !== 8 * pushes)
                    $display("FAIL d8_pops_per_push got=%0d exp=%0d", pops, 8 * pushes);
                else n_pass++;
            end
        end
        n_chk++;
        if (pushes !== 12 || pops !== 100)
            $display("FAIL d8_count got pops=%0d pushes=%0d exp 100/12", pops, pushes);
        else n_pass++;
        for (int c = 0; c < 200 && pushes < 13; c++) begin
            @(negedge clock);
            bus8.in_empty = (pops >= 104);
            #1;
            if (bus8.in_rd_en) pops++;
            if (bus8.out_wr_en) pushes++;
        end
        n_chk++;
        if (pushes !== 13 || pops !== 104)
            $display("FAIL d8_residue got pops=%0d pushes=%0d exp 104/13", pops, pushes);
        else n_pass++;
        bus8.in_empty = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit found = 0, seen = 0;
        @(negedge clock);
        bus.in_empty = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clock);
            bus.in_empty = 1'b1;
            #1;
            found = bus.mac_en && bus.coef_addr == 5'd7;
        end
        n_chk++;
        if (!found) $display("FAIL rm_reach_tap7 got=none exp=tap 7");
        else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++;
        if ({bus.mac_en, bus.hist_wr_en, bus.in_rd_en, bus.busy} !== 4'b0001 ||
            bus.coef_addr !== 5'd0 || bus.hist_rd_addr !== 5'd0)
            $display("FAIL rm_async got en/wr/rd/busy=%b%b%b%b coef=%0d rd=%0d exp 0001 0 0",
                     bus.mac_en, bus.hist_wr_en, bus.in_rd_en, bus.busy,
                     bus.coef_addr, bus.hist_rd_addr);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        ptr = '0;
        #1;
        n_chk++;
        if ({bus.hist_wr_en, bus.hist_zero} !== 2'b11 || bus.hist_wr_addr !== 5'd0)
            $display("FAIL rm_clear_start got=%b%b addr=%0d exp 11 addr=0",
                     bus.hist_wr_en, bus.hist_zero, bus.hist_wr_addr);
        else n_pass++;
        repeat (31) @(negedge clock);
        #1;
        n_chk++;
        if ({bus.hist_wr_en, bus.hist_zero} !== 2'b11 || bus.hist_wr_addr !== 5'd31)
            $display("FAIL rm_clear_end got=%b%b addr=%0d exp 11 addr=31",
                     bus.hist_wr_en, bus.hist_zero, bus.hist_wr_addr);
        else n_pass++;
        @(negedge clock);
        bus.in_empty = 1'b0;
        #1;
        n_chk++;
        if (bus.in_rd_en !== 1'b1 || bus.hist_wr_addr !== ptr)
            $display("FAIL rm_pop got rd=%b addr=%0d exp 1 addr=%0d",
                     bus.in_rd_en, bus.hist_wr_addr, ptr);
        else n_pass++;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clock);
            bus.in_empty = 1'b1;
            #1;
            seen = bus.out_wr_en;
        end
        n_chk++;
        if (!seen) $display("FAIL rm_push got=none exp=push within 40 cycles");
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_decim8();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fir_cmplx_seq.md
Name: fir_cmplx_seq

Overview:
Time-multiplexed tap sequencer for the complex channel FIR. It pops I/Q samples from the input FIFO and writes them into a circular history RAM. For each output it sweeps one shared complex MAC across all taps, then pushes the result into the output FIFO. It sits between the input FIFO, history RAM, coefficient ROM, MAC and output FIFO inside fir_cmplx_top, and owns every strobe and address in that datapath.

Parameters:
NUM_TAPS, 20, filter length; must be <= 2**ADDR_WIDTH
ADDR_WIDTH, 5, history RAM address width (depth 32)
DECIM, 1, input samples consumed per output; must be >= 1
MAC_LATENCY, 2, MAC pipeline depth from last mac_en to result valid

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_empty  in  1  input FIFO empty (first-word-fall-through)
in_rd_en  out  1  input FIFO pop
hist_wr_en  out  1  history RAM write strobe
hist_zero  out  1  write zero instead of FIFO data (clear pass)
hist_wr_addr  out  ADDR_WIDTH  history write address
hist_rd_addr  out  ADDR_WIDTH  history read address
coef_addr  out  $clog2(NUM_TAPS)  coefficient ROM address
mac_en  out  1  MAC accumulate strobe
mac_clear  out  1  load product instead of accumulating (first tap)
mac_last  out  1  final tap of current output
out_full  in  1  output FIFO full
out_wr_en  out  1  output FIFO push
busy  out  1  high in every state except S_READ

Behaviour:
- Reset (reset=0, async): state=S_CLEAR, wr_ptr=0, clr_cnt=0, decim_cnt=0, tap=0, drain=0. All strobes and addresses drop to 0 immediately, with no clock edge needed. busy=1.
- S_CLEAR: hist_wr_en=1, hist_zero=1, hist_wr_addr=clr_cnt, for 2**ADDR_WIDTH cycles (addresses 0..31). Then go to S_READ. clr_cnt is not reused afterwards.
- S_READ: in_rd_en = hist_wr_en = !in_empty (combinational, same cycle). hist_zero=0, hist_wr_addr=wr_ptr.
- On each pop: wr_ptr increments mod 2**ADDR_WIDTH and decim_cnt increments.
- When a pop occurs with decim_cnt==DECIM-1: decim_cnt=0, newest=wr_ptr (the pre-increment value), next state S_MAC.
- S_MAC: one tap per cycle, tap k=0..NUM_TAPS-1. Drives mac_en=1, coef_addr=k, hist_rd_addr=(newest-k) mod 2**ADDR_WIDTH.
  - mac_clear=1 only at k=0; mac_last=1 only at k=NUM_TAPS-1.
  - After the last tap, go to S_DRAIN.
  - No FIFO pops occur in S_MAC, regardless of in_empty.
- S_DRAIN: all strobes 0 for MAC_LATENCY cycles, then S_WRITE.
- S_WRITE: out_wr_en = !out_full (combinational).
  - On push, go to S_READ.
  - While out_full=1, hold in S_WRITE with all other strobes 0; the MAC result must remain stable.
- Latency: DECIM=1 with a continuous stream gives a pop-to-push of 1+NUM_TAPS+MAC_LATENCY cycles, and one output every 24 cycles at the defaults.
- hist_wr_addr, hist_rd_addr and coef_addr are registered-state derived and glitch-free. in_rd_en, hist_wr_en and out_wr_en are combinational from state and the FIFO flags.
- Simultaneous events:
  - in_empty falling during S_MAC, S_DRAIN or S_WRITE is ignored until S_READ.
  - out_full is sampled only in S_WRITE.
- Wrap: wr_ptr and read-address arithmetic are modulo 2**ADDR_WIDTH and never saturate.

Test Plan:
1. Release reset with in_empty=1 -> 32 cycles of hist_wr_en=1, hist_zero=1, hist_wr_addr 0..31; then busy=0 and in_rd_en=0 indefinitely.
2. One sample (in_empty low for 1 cycle), DECIM=1 -> in_rd_en=1 with hist_wr_addr=0; then 20 mac_en cycles with coef_addr 0..19 and hist_rd_addr 0,31,30..13; mac_clear on cycle 1, mac_last on cycle 20; 2 idle cycles; one out_wr_en pulse.
3. 100 samples with in_empty=0 continuously -> exactly 100 out_wr_en pulses spaced 24 cycles; the 33rd pop uses hist_wr_addr=0 again and its rd sweep is 0,31..13.
4. out_full=1 for 10 cycles on entering S_WRITE -> out_wr_en=0 and in_rd_en=0 for those 10 cycles; one out_wr_en pulse on the first cycle out_full=0; next pop the cycle after.
5. DECIM=8 build, 100 samples -> 12 outputs, each after 8 pops; decim_cnt=4 at the end; no 13th push.
6. Assert reset at tap 7 of S_MAC -> mac_en falls the same instant; after release, the S_CLEAR pass repeats from address 0 and wr_ptr restarts at 0.
